alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Instruction-side initiator for the combinational ALU (ALU control decode plus ALU core). It accepts a 32-bit MIPS instruction and its register operands over a valid/ready handshake, then slices the opcode and funct fields. It forms the A/B operands, with the sign-extended immediate used for lw/sw, and drives them to the ALU for exactly one cycle. It captures result/zero, evaluates beq, and returns ordered responses through a buffered valid/ready output.

## Interface
- RESP_DEPTH, 4, response FIFO depth (legal ≥2; ≥3 required for 1 instr/cycle sustained).
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction request valid
- in_ready  out  1  request accepted when in_valid && in_ready at rising edge
- in_instr  in  32  MIPS instruction word
- in_pc  in  32  PC of instruction
- in_rs_val  in  32  value of register rs
- in_rt_val  in  32  value of register rt
- alu_opcode  out  6  to ALU opcode
- alu_func  out  6  to ALU func_field
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_result  in  32  ALU result (combinational from alu_* ports)
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid && out_ready
- out_result  out  32  ALU result (0 for illegal)
- out_zero  out  1  ALU zero flag (0 for illegal)
- out_kind  out  2  0 R-type, 1 mem address (lw/sw), 2 branch (beq), 3 illegal
- out_taken  out  1  beq taken
- out_target  out  32  next PC
- out_pc  out  32  echoed in_pc

## Operation
- Decode at accept: opcode = instr[31:26], func = instr[5:0], imm = instr[15:0], simm = sign-extend(imm) to 32.
- Legal set:
  - opcode 0x00 with funct ∈ {0x20,0x22,0x24,0x25,0x27,0x2A}: kind 0.
  - opcode 0x23/0x2B: kind 1.
  - opcode 0x04: kind 2.
  - Everything else: kind 3.
- Operands:
  - A = rs_val.
  - B = rt_val for opcode 0x00/0x04; B = simm for 0x23/0x2B.
  - Illegal: A = B = 0.
  - alu_opcode/alu_func are always the raw instruction fields.
- Issue stage: registers (issue_vld, alu_opcode, alu_func, alu_a, alu_b, kind, pc, simm) load on accept. issue_vld clears when no accept. When idle, alu_* hold their last values.
- Capture: while issue_vld=1, push into the FIFO:
  - result = alu_result (kind 3: 0);
  - zero = alu_zero (kind 3: 0);
  - taken = (kind==2) && alu_zero;
  - target = taken ? pc+4+(simm<<2) : pc+4, mod 2^32.
- The block does not reinterpret ALU arithmetic: slt is whatever the ALU computes (unsigned compare), and add/sub wrap mod 2^32.
- Flow control: in_ready = !rst && (fifo_count + issue_vld < RESP_DEPTH). There is no combinational out_ready→in_ready path.
  - This guarantees every issued instruction has a FIFO slot, so the capture push never overflows.
  - Total in flight ≤ RESP_DEPTH.
- FIFO: registered and in order. Simultaneous push and pop is allowed at any count, including full-with-pop, and the count is unchanged. out_* come from the head entry. While out_valid && !out_ready, all out_* hold stable.

## Timing
- Reset (rst high at an edge) clears issue_vld, fifo_count, and pointers. Register reset values:
  - alu_opcode/alu_func/alu_a/alu_b = 0;
  - out_valid = 0, out_result = 0, out_zero = 0, out_kind = 0, out_taken = 0, out_target = 0, out_pc = 0.
- in_ready = 0 while rst is high. After reset, in_ready = 1 in the first cycle with rst low.
- Reset mid-operation discards issue and FIFO contents. No stale out_valid follows.
- Latency, accept at edge N:
  - alu_* are driven during cycle N+1.
  - The FIFO push occurs at edge N+2.
  - out_valid = 1 in cycle N+2 if the FIFO was empty.
- Throughput: 1 instr/cycle with out_ready=1 and RESP_DEPTH≥3. With RESP_DEPTH=2, throughput is 1 instr / 2 cycles.
- out_valid deasserts the cycle after the last entry pops.

## Test plan
- Add: instr 0x00221820, rs=5, rt=7, accept at edge N → alu_a=5, alu_b=7 in N+1; out_valid in N+2 with out_result=12, out_kind=0, out_zero=0, out_target=pc+4.
- Unsigned slt: funct 0x2A (instr 0x0022182A), rs=0xFFFFFFFF, rt=1 → out_result=0, out_zero=1. Sub with rs=rt=3 (instr 0x00221822) → out_result=0, out_zero=1.
- lw: instr 0x8C22FFFC, rs=0x1000 → alu_b=0xFFFFFFFC, out_result=0x00000FFC, kind=1. sw 0xAC220010, rs=0x20 → 0x30, kind=1.
- beq: instr 0x10220003, pc=0x100; rs=rt=9 → out_taken=1, out_target=0x110. rs=9, rt=8 → out_taken=0, out_target=0x104, kind=2.
- Backpressure: RESP_DEPTH=4, out_ready=0, in_valid held with 6 distinct adds → exactly 4 accepted, then in_ready=0. Raise out_ready → 6 responses in order, out_* stable while stalled, no loss or duplicate. Out_ready=1 stream → 1 response/cycle.
- Illegal and reset:
  - opcode 0x08 → kind=3, out_result=0, out_taken=0.
  - R-type funct 0x21 → kind=3.
  - rst asserted with 3 in flight → out_valid=0 and in_ready=0 during reset; no responses afterward; the next add returns correctly.

Source files
------------

// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signals of the ALU issue unit.
// The slave side is the issue unit. The master side is whoever feeds
// instructions, hosts the combinational ALU and consumes responses.
interface alu_issue_if;
    // instruction request
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    // ALU drive and return
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    // response
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [1:0]  out_kind;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs_val, in_rt_val,
        input  alu_result, alu_zero, out_ready,
        output in_ready, alu_opcode, alu_func, alu_a, alu_b,
        output out_valid, out_result, out_zero, out_kind, out_taken, out_target, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs_val, in_rt_val,
        output alu_result, alu_zero, out_ready,
        input  in_ready, alu_opcode, alu_func, alu_a, alu_b,
        input  out_valid, out_result, out_zero, out_kind, out_taken, out_target, out_pc
    );
endinterface

// File: rtl/alu_issue_unit.sv
// ALU issue unit: decodes a MIPS instruction, drives the external
// combinational ALU for one cycle, captures its result, resolves beq and
// returns ordered responses through a small response FIFO.
module alu_issue_unit #(
    parameter int RESP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef enum logic [1:0] {
        KIND_R   = 2'd0,
        KIND_MEM = 2'd1,
        KIND_BR  = 2'd2,
        KIND_ILL = 2'd3
    } kind_e;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        kind_e       kind;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
    } resp_t;

    // issue stage
    logic        issue_vld_q,  issue_vld_d;
    logic [5:0]  alu_opcode_q, alu_opcode_d;
    logic [5:0]  alu_func_q,   alu_func_d;
    logic [31:0] alu_a_q,      alu_a_d;
    logic [31:0] alu_b_q,      alu_b_d;
    kind_e       kind_q,       kind_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] simm_q,       simm_d;

    // response FIFO
    resp_t            fifo_mem [RESP_DEPTH];
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic        taken;
    resp_t       push_entry;
    resp_t       head;
    kind_e       dec_kind;
    logic [31:0] dec_simm;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == RESP_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Every issued instruction already owns a FIFO slot, so the capture push
    // can never find the FIFO full.
    assign bus.in_ready = !rst && ((int'(fifo_count_q) + int'(issue_vld_q)) < RESP_DEPTH);
    assign accept       = bus.in_valid && bus.in_ready;

    // Decode the incoming instruction and load the issue stage on accept.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        dec_simm     = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
        dec_kind     = KIND_ILL;
        issue_vld_d  = accept;
        alu_opcode_d = alu_opcode_q;
        alu_func_d   = alu_func_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        kind_d       = kind_q;
        pc_d         = pc_q;
        simm_d       = simm_q;

        case (bus.in_instr[31:26])
            6'h00: begin
                if (bus.in_instr[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) begin
                    dec_kind = KIND_R;
                end
            end
            6'h23, 6'h2B: dec_kind = KIND_MEM;
            6'h04:        dec_kind = KIND_BR;
            default:      dec_kind = KIND_ILL;
        endcase

        if (accept) begin
            alu_opcode_d = bus.in_instr[31:26];
            alu_func_d   = bus.in_instr[5:0];
            kind_d       = dec_kind;
            pc_d         = bus.in_pc;
            simm_d       = dec_simm;
            case (dec_kind)
                KIND_R, KIND_BR: begin
                    alu_a_d = bus.in_rs_val;
                    alu_b_d = bus.in_rt_val;
                end
                KIND_MEM: begin
                    alu_a_d = bus.in_rs_val;
                    alu_b_d = dec_simm;
                end
                default: begin
                    alu_a_d = '0;
                    alu_b_d = '0;
                end
            endcase
        end
    end

    // Capture the ALU outputs, resolve beq and advance the FIFO bookkeeping.
    always_comb begin
        push  = issue_vld_q;
        pop   = bus.out_valid && bus.out_ready;
        taken = (kind_q == KIND_BR) && bus.alu_zero;

        push_entry.result = (kind_q == KIND_ILL) ? '0 : bus.alu_result;
        push_entry.zero   = (kind_q == KIND_ILL) ? 1'b0 : bus.alu_zero;
        push_entry.kind   = kind_q;
        push_entry.taken  = taken;
        push_entry.target = taken ? (pc_q + 32'd4 + (simm_q << 2)) : (pc_q + 32'd4);
        push_entry.pc     = pc_q;

        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            issue_vld_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_func_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            kind_q       <= KIND_R;
            pc_q         <= '0;
            simm_q       <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            issue_vld_q  <= issue_vld_d;
            alu_opcode_q <= alu_opcode_d;
            alu_func_q   <= alu_func_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            kind_q       <= kind_d;
            pc_q         <= pc_d;
            simm_q       <= simm_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; outputs are forced to zero while the
        // FIFO is empty, so stale entries are never visible.
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    assign head = fifo_mem[rd_ptr_q];

    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_func   = alu_func_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;

    assign bus.out_valid  = (fifo_count_q != '0);
    assign bus.out_result = bus.out_valid ? head.result : '0;
    assign bus.out_zero   = bus.out_valid ? head.zero   : 1'b0;
    assign bus.out_kind   = bus.out_valid ? head.kind   : KIND_R;
    assign bus.out_taken  = bus.out_valid ? head.taken  : 1'b0;
    assign bus.out_target = bus.out_valid ? head.target : '0;
    assign bus.out_pc     = bus.out_valid ? head.pc     : '0;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a stand-in ALU, a reference
// model feeding a scoreboard queue, directed vectors and a random stream.
module tb_alu_issue_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus();

    alu_issue_unit #(.RESP_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [1:0]  kind;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   accepts  = 0;
    int   pops     = 0;
    int   pop_cycles[$];
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Stand-in ALU; unknown encodings return garbage with zero set so that
    // the unit must suppress them for illegal instructions.
    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   return a + b;
                    6'h22:   return a - b;
                    6'h24:   return a & b;
                    6'h25:   return a | b;
                    6'h27:   return ~(a | b);
                    6'h2A:   return {31'd0, (a < b)};
                    default: return 32'hDEADBEEF;
                endcase
            end
            6'h23, 6'h2B: return a + b;
            6'h04:        return a - b;
            default:      return 32'hDEADBEEF;
        endcase
    endfunction

    assign bus.alu_result = ref_alu(bus.alu_opcode, bus.alu_func, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 32'd0) || (bus.alu_result == 32'hDEADBEEF);

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [31:0] simm;
        e.op = instr[31:26];
        e.fn = instr[5:0];
        simm = {{16{instr[15]}}, instr[15:0]};
        if (e.op == 6'h00 && (e.fn == 6'h20 || e.fn == 6'h22 || e.fn == 6'h24 ||
                              e.fn == 6'h25 || e.fn == 6'h27 || e.fn == 6'h2A)) e.kind = 2'd0;
        else if (e.op == 6'h23 || e.op == 6'h2B) e.kind = 2'd1;
        else if (e.op == 6'h04)                  e.kind = 2'd2;
        else                                     e.kind = 2'd3;
        e.a      = (e.kind == 2'd3) ? 32'd0 : rs;
        e.b      = (e.kind == 2'd3) ? 32'd0 : ((e.kind == 2'd1) ? simm : rt);
        e.result = (e.kind == 2'd3) ? 32'd0 : ref_alu(e.op, e.fn, e.a, e.b);
        e.zero   = (e.kind != 2'd3) && (e.result == 32'd0);
        e.taken  = (e.kind == 2'd2) && e.zero;
        e.target = e.taken ? pc + 32'd4 + {simm[29:0], 2'b00} : pc + 32'd4;
        e.pc     = pc;
        return e;
    endfunction

    // Monitor: scoreboard push on accept, pop/compare on response, stall stability.
    exp_t alu_exp;
    bit   alu_pend  = 1'b0;
    bit   stall_pend = 1'b0;
    logic [31:0] snap_result, snap_target, snap_pc;
    logic [3:0]  snap_flags;
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            alu_pend   = 1'b0;
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_result", bus.out_result, snap_result);
                check("stall_target", bus.out_target, snap_target);
                check("stall_pc",     bus.out_pc,     snap_pc);
                check("stall_flags",  {28'd0, bus.out_zero, bus.out_kind, bus.out_taken},
                                      {28'd0, snap_flags});
            end
            stall_pend  = bus.out_valid && !bus.out_ready;
            snap_result = bus.out_result;
            snap_target = bus.out_target;
            snap_pc     = bus.out_pc;
            snap_flags  = {bus.out_zero, bus.out_kind, bus.out_taken};
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                pop_cycles.push_back(cyc);
                check("resp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_result", bus.out_result, e.result);
                    check("resp_zero",   {31'd0, bus.out_zero},  {31'd0, e.zero});
                    check("resp_kind",   {30'd0, bus.out_kind},  {30'd0, e.kind});
                    check("resp_taken",  {31'd0, bus.out_taken}, {31'd0, e.taken});
                    check("resp_target", bus.out_target, e.target);
                    check("resp_pc",     bus.out_pc,     e.pc);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.in_instr, bus.in_pc, bus.in_rs_val, bus.in_rt_val);
                sb.push_back(e);
                alu_exp  = e;
                alu_pend = 1'b1;
                accepts++;
            end
        end
    end

    // ALU drive is checked in the cycle after acceptance.
    always @(negedge clk) begin
        if (alu_pend) begin
            alu_pend = 1'b0;
            check("alu_a",      bus.alu_a, alu_exp.a);
            check("alu_b",      bus.alu_b, alu_exp.b);
            check("alu_opcode", {26'd0, bus.alu_opcode}, {26'd0, alu_exp.op});
            check("alu_func",   {26'd0, bus.alu_func},   {26'd0, alu_exp.fn});
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.in_rs_val = rs;
        bus.in_rt_val = rt;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_in_time", 32'(n < 300), 32'd1);
        if (n < 300) @(posedge clk);
        else bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] res, input logic zero,
                               input logic [1:0] kind, input logic taken, input logic [31:0] tgt);
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_result"}, bus.out_result, res);
        check({tag, "_zero"},   {31'd0, bus.out_zero},  {31'd0, zero});
        check({tag, "_kind"},   {30'd0, bus.out_kind},  {30'd0, kind});
        check({tag, "_taken"},  {31'd0, bus.out_taken}, {31'd0, taken});
        check({tag, "_target"}, bus.out_target, tgt);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < 200), 32'd1);
    endtask

    function automatic logic [31:0] r_instr(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    initial begin
        int base;
        logic [5:0]  ops[4];
        logic [5:0]  fns[7];
        logic [31:0] ins, rsv, rtv;
        ops = '{6'h00, 6'h23, 6'h04, 6'h08};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21};

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.in_rs_val = '0;
        bus.in_rt_val = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",   {31'd0, bus.in_ready},  32'd0);
        check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_alu_a",      bus.alu_a, 32'd0);
        check("rst_alu_b",      bus.alu_b, 32'd0);
        check("rst_alu_op",     {20'd0, bus.alu_opcode, bus.alu_func}, 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_target", bus.out_target, 32'd0);
        check("rst_out_misc",   {bus.out_pc[27:0], bus.out_zero, bus.out_kind, bus.out_taken}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // add latency: alu_* in N+1, response in N+2
        bus.out_ready = 1'b1;
        send(32'h00221820, 32'h40, 32'd5, 32'd7);
        idle();
        check("add_n1_alu_a",     bus.alu_a, 32'd5);
        check("add_n1_alu_b",     bus.alu_b, 32'd7);
        check("add_n1_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("add_n2_out_valid", {31'd0, bus.out_valid}, 32'd1);
        expect_head("add", 32'd12, 1'b0, 2'd0, 1'b0, 32'h44);
        drain();

        send(32'h0022182A, 32'h44, 32'hFFFFFFFF, 32'd1); idle();
        expect_head("slt", 32'd0, 1'b1, 2'd0, 1'b0, 32'h48); drain();
        send(32'h00221822, 32'h48, 32'd3, 32'd3); idle();
        expect_head("sub", 32'd0, 1'b1, 2'd0, 1'b0, 32'h4C); drain();
        send(32'h8C22FFFC, 32'h50, 32'h1000, 32'h55); idle();
        check("lw_alu_b", bus.alu_b, 32'hFFFFFFFC);
        expect_head("lw", 32'h00000FFC, 1'b0, 2'd1, 1'b0, 32'h54); drain();
        send(32'hAC220010, 32'h54, 32'h20, 32'h99); idle();
        expect_head("sw", 32'h30, 1'b0, 2'd1, 1'b0, 32'h58); drain();
        send(32'h10220003, 32'h100, 32'd9, 32'd9); idle();
        expect_head("beq_t", 32'd0, 1'b1, 2'd2, 1'b1, 32'h110); drain();
        send(32'h10220003, 32'h100, 32'd9, 32'd8); idle();
        expect_head("beq_nt", 32'd1, 1'b0, 2'd2, 1'b0, 32'h104); drain();
        send(32'h1022FFFE, 32'h200, 32'd4, 32'd4); idle();
        expect_head("beq_back", 32'd0, 1'b1, 2'd2, 1'b1, 32'h1FC); drain();
        send(32'h20221234, 32'h300, 32'd1, 32'd2); idle();
        check("ill_alu_ab", bus.alu_a | bus.alu_b, 32'd0);
        expect_head("ill_op", 32'd0, 1'b0, 2'd3, 1'b0, 32'h304); drain();
        send(32'h00221821, 32'h304, 32'd1, 32'd2); idle();
        expect_head("ill_fn", 32'd0, 1'b0, 2'd3, 1'b0, 32'h308); drain();

        // backpressure: 6 adds offered, only 4 fit while out_ready is low
        @(negedge clk);
        bus.out_ready = 1'b0;
        base = accepts;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h00221820, 32'h400 + 32'(4 * i), 32'(i), 32'd100);
                idle();
            end
            begin
                repeat (15) @(negedge clk);
                check("bp_accepted", 32'(accepts - base), 32'd4);
                check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_total", 32'(accepts - base), 32'd6);

        // streaming: 8 back-to-back gives 8 responses on consecutive cycles
        base = pop_cycles.size();
        for (int i = 0; i < 8; i++) send(r_instr(6'h25), 32'h500 + 32'(4 * i), 32'(i), 32'h10);
        idle();
        drain();
        check("stream_count", 32'(pop_cycles.size() - base), 32'd8);
        if (pop_cycles.size() - base == 8)
            check("stream_rate", 32'(pop_cycles[base + 7] - pop_cycles[base]), 32'd7);

        // random mix with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rsv = $urandom();
                    rtv = ($urandom_range(0, 2) == 0) ? rsv : $urandom();
                    if (ops[i % 4] == 6'h00) ins = r_instr(fns[$urandom_range(0, 6)]);
                    else ins = {ops[i % 4], 5'd1, 5'd2, 16'($urandom())};
                    send(ins, $urandom(), rsv, rtv);
                end
                idle();
            end
            begin
                repeat (80) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // reset with three in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h00221820, 32'h600 + 32'(4 * i), 32'd1, 32'd1);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = pops;
        repeat (10) @(negedge clk);
        check("post_rst_no_resp", 32'(pops - base), 32'd0);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        send(32'h00221820, 32'h700, 32'd20, 32'd22); idle();
        expect_head("post_rst_add", 32'd42, 1'b0, 2'd0, 1'b0, 32'h704); drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
